// File: rtl/forward_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | forward_stage                                                              |
// | Single-entry rdy/ack pipeline control stage; the parent holds the payload  |
// | and loads it on src_ack. Includes a simulation-only protocol checker.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module forward_stage (
  input  logic i_clk,
  input  logic i_rst,
  input  logic src_rdy,
  output logic src_ack,
  output logic dst_rdy,
  input  logic dst_ack
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_state_en;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_EMPTY;
    end else if (w_state_en) begin
      r_state <= w_state_next;
    end
  end

  // Accept while empty, or while the held token drains in the same cycle.
  always_comb begin
    w_state_next = r_state;
    src_ack      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        src_ack = src_rdy;
        if (src_rdy) w_state_next = S_FULL;
      end
      S_FULL: begin
        src_ack = src_rdy & dst_ack;
        if (dst_ack && !src_rdy) w_state_next = S_EMPTY;
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase
  end

  assign w_state_en = (w_state_next != r_state);
  assign dst_rdy    = (r_state == S_FULL);

`ifndef SYNTHESIS
  a_src_ack_needs_rdy: assert property (@(posedge i_clk) disable iff (!i_rst)
    src_ack |-> src_rdy);

  a_dst_ack_needs_rdy: assert property (@(posedge i_clk) disable iff (!i_rst)
    dst_ack |-> dst_rdy);

  a_src_rdy_held: assert property (@(posedge i_clk) disable iff (!i_rst)
    (src_rdy && !src_ack) |=> src_rdy);

  a_dst_rdy_held: assert property (@(posedge i_clk) disable iff (!i_rst)
    (dst_rdy && !dst_ack) |=> dst_rdy);

  a_no_x_outputs: assert property (@(posedge i_clk) disable iff (!i_rst)
    !$isunknown({src_ack, dst_rdy}));

  a_no_x_inputs: assert property (@(posedge i_clk) disable iff (!i_rst)
    !$isunknown({src_rdy, dst_ack}));

  // Structural properties of the stage itself.
  a_accept_fills: assert property (@(posedge i_clk) disable iff (!i_rst)
    src_ack |=> dst_rdy);

  a_backpressure: assert property (@(posedge i_clk) disable iff (!i_rst)
    (dst_rdy && !dst_ack) |-> !src_ack);

  a_drain_empties: assert property (@(posedge i_clk) disable iff (!i_rst)
    (dst_rdy && dst_ack && !src_rdy) |=> !dst_rdy);

  c_pass_through: cover property (@(posedge i_clk) disable iff (!i_rst)
    dst_rdy && dst_ack && src_ack);
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_forward_stage                                                           |
// | Directed vector table plus streaming, backpressure, random and reset runs. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_forward_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic src_rdy = 1'b0;
  logic dst_ack = 1'b0;
  logic src_ack;
  logic dst_rdy;

  forward_stage dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .src_rdy (src_rdy),
    .src_ack (src_ack),
    .dst_rdy (dst_rdy),
    .dst_ack (dst_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sr;
    logic da;
    logic esa;
    logic edr;
  } vec_t;

  vec_t tbl [15];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   sb_en  = 1'b0;
  int   in_cnt = 0;
  int   out_cnt = 0;
  int   payload = -1;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive, settle, compare, then update the
  // parent-side payload model for the upcoming rising edge.
  task automatic apply(input logic sr, input logic da, input logic esa,
                       input logic edr, input string nm);
    src_rdy = sr;
    dst_ack = da;
    #1;
    chk({nm, "_src_ack"}, src_ack, esa);
    chk({nm, "_dst_rdy"}, dst_rdy, edr);
    if (sb_en) begin
      if (dst_rdy && dst_ack) begin
        chk_int({nm, "_payload"}, payload, out_cnt);
        out_cnt++;
      end
      if (src_ack) begin
        payload = in_cnt;
        in_cnt++;
      end
    end
  endtask

  task automatic cyc(input logic sr, input logic da, input logic esa,
                     input logic edr, input string nm);
    @(negedge clk);
    apply(sr, da, esa, edr, nm);
  endtask

  initial begin
    logic sr;
    logic da;
    logic sr_hold;
    logic m_full;
    int   guard;

    //         sr    da    esa   edr
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset before any rising edge.
    #1 rst_n = 1'b0;
    src_rdy = 1'($urandom_range(0, 1));
    dst_ack = 1'($urandom_range(0, 1));
    #2;
    chk("rst_dst_rdy", dst_rdy, 1'b0);
    chk("rst_src_ack", src_ack, src_rdy);
    @(negedge clk);
    src_rdy = 1'b0;
    dst_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].sr, tbl[i].da, tbl[i].esa, tbl[i].edr, $sformatf("tbl%0d", i));
    end

    // Streaming: payload counter 0..9, consumed every cycle.
    sb_en   = 1'b1;
    in_cnt  = 0;
    out_cnt = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "stream0");
    for (int i = 1; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b1, $sformatf("stream%0d", i));
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "stream_drain");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "stream_idle");
    chk_int("stream_count", out_cnt, 10);

    // Backpressure: held token must not be overwritten.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "bp_fill");
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, $sformatf("bp_hold%0d", i));
      chk_int($sformatf("bp_payload%0d", i), payload, 10);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, "bp_release");
    chk_int("bp_next_loaded", payload, 11);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "bp_drain");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "bp_idle");

    // Random rdy/ack traffic against a reference of the stage equations.
    sr_hold = 1'b0;
    m_full  = 1'b0;
    sr      = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!sr_hold) sr = ($urandom_range(0, 99) < 60);
      da = m_full & ($urandom_range(0, 99) < 60);
      apply(sr, da, sr & (~m_full | da), m_full, "rnd");
      sr_hold = sr & ~src_ack;
      m_full  = sr | (m_full & ~da);
    end
    guard = 0;
    while (dst_rdy && guard < 4) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1, "rnd_drain");
      guard++;
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "rnd_idle");
    chk_int("rnd_no_loss", out_cnt, in_cnt);

    // Reset while FULL: held token is discarded.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "mrst_fill");
    @(negedge clk);
    src_rdy = 1'b0;
    dst_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_dst_rdy", dst_rdy, 1'b0);
    chk("mrst_src_ack0", src_ack, 1'b0);
    src_rdy = 1'b1;
    #1;
    chk("mrst_src_ack1", src_ack, 1'b1);
    @(negedge clk);
    src_rdy = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    out_cnt = in_cnt;
    payload = -1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("mrst_idle%0d", i));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "mrst_new");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, "mrst_deliver");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "mrst_end");
    chk_int("mrst_count", out_cnt, in_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
